// File: rtl/oled_spi_pkg.sv
// Shared constants, register map and serializer state encoding for the OLED SPI controller.
package oled_spi_pkg;

  localparam int unsigned ENTRY_W  = 9;
  localparam int unsigned ENTRY_DC = 8;
  localparam int unsigned DIV_W    = 8;
  localparam int unsigned BITCNT_W = 3;

  // Word offsets, decoded from HADDR[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CLKDIV = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_EMPTY   = 2;
  localparam int unsigned STAT_LVL_LSB = 3;
  localparam int unsigned STAT_LVL_W   = 3;
  localparam int unsigned STAT_OVF     = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } state_e;

endpackage

// File: rtl/oled_tx_fifo.sv
// Synchronous TX FIFO holding {DC, byte} entries; first-word-fall-through read port.
module oled_tx_fifo
  import oled_spi_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               pop_i,
  output logic [ENTRY_W-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LVL_W-1:0]   level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [LVL_W-1:0]   level_q;
  logic               do_push_c;
  logic               do_pop_c;

  assign empty_o   = (level_q == '0);
  assign full_o    = (level_q == LVL_W'(DEPTH));
  assign level_o   = level_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign do_pop_c  = pop_i & ~empty_o;
  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle
  assign do_push_c = push_i & (~full_o | do_pop_c);

  always_ff @(posedge clk_i) begin
    if (do_push_c) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push_c && !do_pop_c)      level_q <= level_q + LVL_W'(1);
      else if (do_pop_c && !do_push_c) level_q <= level_q - LVL_W'(1);
    end
  end

endmodule

// File: rtl/ahblite_oled_spi_ctrl.sv
// AHB-Lite slave that serializes queued command/data bytes MSB-first onto the OLED serial bus.
module ahblite_oled_spi_ctrl
  import oled_spi_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DIV_RESET  = 8'd3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic [1:0]  HRESP,
  output logic        OLED_SCLK,
  output logic        OLED_SDIN,
  output logic        OLED_DC,
  output logic        OLED_CS_N
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                trans_en_c;
  logic [1:0]          addr_q;
  logic                wr_q;
  logic [DIV_W-1:0]    clkdiv_q;
  logic                ovf_q;

  logic                push_c;
  logic                pop_c;
  logic                busy_c;
  logic                half_done_c;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_full;
  logic                fifo_empty;
  logic [LVL_W-1:0]    fifo_level;
  logic [31:0]         status_c;

  state_e              state_q;
  logic [7:0]          byte_q;
  logic [DIV_W-1:0]    div_q;
  logic [DIV_W-1:0]    hcnt_q;
  logic [BITCNT_W-1:0] bit_cnt_q;
  logic                sclk_q;
  logic                sdin_q;
  logic                dc_q;
  logic                cs_n_q;

  logic unused_c;
  assign unused_c = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HWDATA[31:9]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign OLED_SCLK = sclk_q;
  assign OLED_SDIN = sdin_q;
  assign OLED_DC   = dc_q;
  assign OLED_CS_N = cs_n_q;

  assign trans_en_c  = HSEL & HTRANS[1] & HREADY;
  assign push_c      = wr_q & (addr_q == REG_TXDATA);
  assign pop_c       = (state_q == ST_IDLE) & ~fifo_empty;
  assign busy_c      = (state_q != ST_IDLE) | ~fifo_empty;
  assign half_done_c = (hcnt_q == '0);

  // Address phase capture
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      wr_q <= trans_en_c & HWRITE;
      if (trans_en_c) addr_q <= HADDR[3:2];
    end
  end

  // Data phase register writes; overflow only when the push is actually dropped
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      clkdiv_q <= DIV_RESET;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_q && (addr_q == REG_CLKDIV)) clkdiv_q <= HWDATA[DIV_W-1:0];
      if (wr_q && (addr_q == REG_STATUS) && HWDATA[STAT_OVF]) ovf_q <= 1'b0;
      else if (push_c && fifo_full && !pop_c)                 ovf_q <= 1'b1;
    end
  end

  oled_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (HCLK),
    .rst_i   (HRESET),
    .push_i  (push_c),
    .wdata_i (HWDATA[ENTRY_W-1:0]),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    status_c = '0;
    status_c[STAT_BUSY]  = busy_c;
    status_c[STAT_FULL]  = fifo_full;
    status_c[STAT_EMPTY] = fifo_empty;
    status_c[STAT_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(fifo_level);
    status_c[STAT_OVF]   = ovf_q;
    HRDATA = '0;
    case (addr_q)
      REG_STATUS: HRDATA = status_c;
      REG_CLKDIV: HRDATA = 32'(clkdiv_q);
      REG_TXDATA,
      REG_RSVD:   HRDATA = '0;
      default:    HRDATA = '0;
    endcase
  end

  // Shift FSM; pins are registered and updated on the transition into each state
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      div_q     <= '0;
      hcnt_q    <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b1;
      sdin_q    <= 1'b1;
      dc_q      <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      if (state_q != ST_IDLE && !half_done_c) hcnt_q <= hcnt_q - DIV_W'(1);
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state_q   <= ST_SETUP;
            byte_q    <= fifo_rdata[7:0];
            div_q     <= clkdiv_q;
            hcnt_q    <= clkdiv_q;
            bit_cnt_q <= BITCNT_W'(7);
            cs_n_q    <= 1'b0;
            dc_q      <= fifo_rdata[ENTRY_DC];
            sdin_q    <= fifo_rdata[7];
            sclk_q    <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (half_done_c) begin
            state_q <= ST_LOW;
            hcnt_q  <= div_q;
            sclk_q  <= 1'b0;
            sdin_q  <= byte_q[bit_cnt_q];
          end
        end
        ST_LOW: begin
          if (half_done_c) begin
            state_q <= ST_HIGH;
            hcnt_q  <= div_q;
            sclk_q  <= 1'b1;
          end
        end
        ST_HIGH: begin
          if (half_done_c) begin
            hcnt_q <= div_q;
            if (bit_cnt_q == '0) begin
              state_q <= ST_GAP;
              cs_n_q  <= 1'b1;
            end else begin
              state_q   <= ST_LOW;
              bit_cnt_q <= bit_cnt_q - BITCNT_W'(1);
              sclk_q    <= 1'b0;
              sdin_q    <= byte_q[bit_cnt_q - BITCNT_W'(1)];
            end
          end
        end
        ST_GAP: begin
          if (half_done_c) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahblite_oled_spi_ctrl.sv
// Randomized bench for the OLED SPI controller: a pin-level frame decoder checked against a queue model.
module tb_ahblite_oled_spi_ctrl;

  localparam int DEPTH = 4;

  logic        HCLK   = 1'b0;
  logic        HRESET = 1'b1;
  logic        HSEL   = 1'b0;
  logic [31:0] HADDR  = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE  = 3'd2;
  logic [3:0]  HPROT  = 4'h3;
  logic        HWRITE = 1'b0;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic [1:0]  HRESP;
  logic        OLED_SCLK, OLED_SDIN, OLED_DC, OLED_CS_N;

  int vectors = 0;
  int errors  = 0;

  always #5 HCLK = ~HCLK;

  ahblite_oled_spi_ctrl #(.FIFO_DEPTH(DEPTH), .DIV_RESET(8'd3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .OLED_SCLK(OLED_SCLK), .OLED_SDIN(OLED_SDIN), .OLED_DC(OLED_DC), .OLED_CS_N(OLED_CS_N)
  );

  // Decoded frame as seen on the pins
  typedef struct {
    logic [7:0] data;
    logic       dc;
    logic       dc_ok;
    int         nbits;
    int         cs_low;
    int         minh;
    int         maxh;
  } frame_t;

  frame_t     cap_q[$];
  frame_t     cur;
  logic       prev_sclk = 1'b1;
  logic       prev_cs   = 1'b1;
  logic       mon_in_frame = 1'b0;
  int         mon_bits = 0;
  int         run_len  = 0;
  int         sclk_rises = 0;
  logic [8:0] burst[8];

  always @(negedge HCLK) begin
    if (HRESET) begin
      mon_in_frame = 1'b0;
      mon_bits = 0;
    end else begin
      if (prev_cs && !OLED_CS_N) begin
        mon_in_frame = 1'b1;
        mon_bits = 0;
        run_len = 1;
        cur.data = '0; cur.dc = OLED_DC; cur.dc_ok = 1'b1; cur.nbits = 0;
        cur.cs_low = 1; cur.minh = 1 << 20; cur.maxh = 0;
      end else if (!prev_cs && !OLED_CS_N && mon_in_frame) begin
        cur.cs_low++;
        if (OLED_DC !== cur.dc) cur.dc_ok = 1'b0;
        if (OLED_SCLK !== prev_sclk) begin
          if (run_len < cur.minh) cur.minh = run_len;
          if (run_len > cur.maxh) cur.maxh = run_len;
          run_len = 1;
          if (OLED_SCLK) begin
            cur.data = {cur.data[6:0], OLED_SDIN};
            mon_bits++;
            cur.nbits = mon_bits;
          end
        end else begin
          run_len++;
        end
      end else if (!prev_cs && OLED_CS_N && mon_in_frame) begin
        if (run_len < cur.minh) cur.minh = run_len;
        if (run_len > cur.maxh) cur.maxh = run_len;
        cap_q.push_back(cur);
        mon_in_frame = 1'b0;
      end
      if (OLED_SCLK && !prev_sclk) sclk_rises++;
    end
    prev_sclk = OLED_SCLK;
    prev_cs   = OLED_CS_N;
  end

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [3:0] off, input logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'h4002000, off};
    @(negedge HCLK);
    bus_idle(); HWDATA = data;
    @(negedge HCLK);
  endtask

  task automatic ahb_read(input logic [3:0] off, output logic [31:0] data);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'h4002000, off};
    @(negedge HCLK);
    data = HRDATA;
    bus_idle();
  endtask

  // Back-to-back TXDATA writes from burst[0..n-1], pipelined address/data phases
  task automatic burst_write(input int n);
    for (int i = 0; i < n; i++) begin
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4002_0000;
      if (i > 0) HWDATA = {23'd0, burst[i-1]};
      @(negedge HCLK);
    end
    bus_idle(); HWDATA = {23'd0, burst[n-1]};
    @(negedge HCLK);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while (cap_q.size() < n && c < budget) begin @(negedge HCLK); c++; end
    vectors++;
    if (cap_q.size() < n) begin
      errors++;
      $display("FAIL frame_wait: got %0d frames, required %0d", cap_q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] st = 32'h1;
    int c = 0;
    while (st[0] && c < budget) begin ahb_read(4'h4, st); c++; end
    vectors++;
    if (st[0]) begin errors++; $display("FAIL idle_wait: STATUS still busy 0x%08h", st); end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    HRESET = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    vectors++; if (OLED_SCLK !== 1'b1) begin errors++; $display("FAIL rst_sclk: got %b want 1", OLED_SCLK); end
    vectors++; if (OLED_SDIN !== 1'b1) begin errors++; $display("FAIL rst_sdin: got %b want 1", OLED_SDIN); end
    vectors++; if (OLED_CS_N !== 1'b1) begin errors++; $display("FAIL rst_csn: got %b want 1", OLED_CS_N); end
    vectors++; if (OLED_DC !== 1'b0)   begin errors++; $display("FAIL rst_dc: got %b want 0", OLED_DC); end
    vectors++; if (HREADYOUT !== 1'b1 || HRESP !== 2'b00) begin
      errors++; $display("FAIL rst_resp: hreadyout %b hresp %b want 1/00", HREADYOUT, HRESP);
    end
    ahb_read(4'h4, rd);
    vectors++; if (rd !== 32'h4) begin errors++; $display("FAIL rst_status: got 0x%08h want 0x00000004", rd); end
    ahb_read(4'h8, rd);
    vectors++; if (rd !== 32'h3) begin errors++; $display("FAIL rst_clkdiv: got 0x%08h want 0x00000003", rd); end
    ahb_read(4'hC, rd);
    vectors++; if (rd !== 32'h0) begin errors++; $display("FAIL rsvd_read: got 0x%08h want 0", rd); end
  endtask

  task automatic test_single_byte();
    int cyc = 0;
    int cs_fall = -1;
    int idle_at = -1;
    ahb_write(4'h8, 32'h0);
    cap_q.delete();
    ahb_write(4'h0, 32'h1A5);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h4002_0004;
    @(negedge HCLK);
    while (idle_at < 0 && cyc < 200) begin
      if (cs_fall < 0 && !OLED_CS_N) cs_fall = cyc;
      else if (cs_fall >= 0 && !HRDATA[0]) idle_at = cyc;
      if (idle_at < 0) begin @(negedge HCLK); cyc++; end
    end
    bus_idle();
    // The pop happens in the cycle just before CS_N drops
    vectors++; if (idle_at - (cs_fall - 1) != 19 || cs_fall < 0) begin
      errors++; $display("FAIL busy_clear: got %0d cycles after pop, want 19", idle_at - (cs_fall - 1));
    end
    wait_frames(1, 20);
    if (cap_q.size() >= 1) begin
      vectors++; if (cap_q[0].data !== 8'hA5) begin errors++; $display("FAIL single_data: got 0x%02h want 0xa5", cap_q[0].data); end
      vectors++; if (cap_q[0].dc !== 1'b1 || !cap_q[0].dc_ok) begin errors++; $display("FAIL single_dc: got %b stable %b want 1", cap_q[0].dc, cap_q[0].dc_ok); end
      vectors++; if (cap_q[0].nbits != 8) begin errors++; $display("FAIL single_nbits: got %0d want 8", cap_q[0].nbits); end
      vectors++; if (cap_q[0].cs_low != 17) begin errors++; $display("FAIL single_cslow: got %0d want 17", cap_q[0].cs_low); end
      vectors++; if (cap_q[0].minh != 1 || cap_q[0].maxh != 1) begin
        errors++; $display("FAIL single_half: got %0d..%0d want 1", cap_q[0].minh, cap_q[0].maxh);
      end
    end
    vectors++; if (OLED_DC !== 1'b1) begin errors++; $display("FAIL dc_hold: got %b want 1", OLED_DC); end
  endtask

  task automatic test_clkdiv();
    logic [31:0] rd;
    ahb_write(4'h8, 32'h4);
    ahb_read(4'h8, rd);
    vectors++; if (rd !== 32'h4) begin errors++; $display("FAIL clkdiv_rb: got 0x%08h want 4", rd); end
    cap_q.delete();
    ahb_write(4'h0, 32'h0AE);
    wait_frames(1, 200);
    if (cap_q.size() >= 1) begin
      vectors++; if (cap_q[0].data !== 8'hAE) begin errors++; $display("FAIL div_data: got 0x%02h want 0xae", cap_q[0].data); end
      vectors++; if (cap_q[0].dc !== 1'b0) begin errors++; $display("FAIL div_dc: got %b want 0", cap_q[0].dc); end
      vectors++; if (cap_q[0].minh != 5 || cap_q[0].maxh != 5) begin
        errors++; $display("FAIL div_half: got %0d..%0d want 5", cap_q[0].minh, cap_q[0].maxh);
      end
      vectors++; if (cap_q[0].cs_low != 85) begin errors++; $display("FAIL div_cslow: got %0d want 85", cap_q[0].cs_low); end
    end
    wait_idle(50);
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    ahb_write(4'h8, 32'h1);
    for (int i = 0; i < 6; i++) burst[i] = 9'(i + 1);
    cap_q.delete();
    burst_write(6);
    ahb_read(4'h4, rd);
    vectors++; if (rd !== 32'h123) begin errors++; $display("FAIL ovf_status: got 0x%08h want 0x00000123", rd); end
    wait_frames(5, 500);
    wait_idle(50);
    vectors++; if (cap_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d frames want 5", cap_q.size()); end
    for (int i = 0; i < 5 && i < cap_q.size(); i++) begin
      vectors++; if (cap_q[i].data !== 8'(i + 1)) begin
        errors++; $display("FAIL ovf_order[%0d]: got 0x%02h want 0x%02h", i, cap_q[i].data, 8'(i + 1));
      end
    end
    ahb_write(4'h4, 32'h100);
    ahb_read(4'h4, rd);
    vectors++; if (rd !== 32'h4) begin errors++; $display("FAIL ovf_clear: got 0x%08h want 0x00000004", rd); end
  endtask

  task automatic test_random_bursts();
    logic [31:0] st;
    int d, n, exp_n;
    logic exp_ovf;
    for (int r = 0; r < 6; r++) begin
      d = $urandom_range(0, 2);
      n = $urandom_range(1, 6);
      ahb_write(4'h8, 32'(d));
      for (int i = 0; i < n; i++) burst[i] = 9'($urandom);
      // First entry leaves the FIFO at once, DEPTH more fit, the rest are dropped
      exp_n   = (n > DEPTH + 1) ? DEPTH + 1 : n;
      exp_ovf = (n > DEPTH + 1);
      cap_q.delete();
      burst_write(n);
      ahb_read(4'h4, st);
      vectors++; if (st[8] !== exp_ovf) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", r, st[8], exp_ovf); end
      wait_frames(exp_n, exp_n * (19 * (d + 1) + 4) + 50);
      wait_idle(50);
      vectors++; if (cap_q.size() != exp_n) begin errors++; $display("FAIL rnd_count[%0d]: got %0d want %0d", r, cap_q.size(), exp_n); end
      for (int i = 0; i < exp_n && i < cap_q.size(); i++) begin
        vectors++;
        if (cap_q[i].data !== burst[i][7:0] || cap_q[i].dc !== burst[i][8] || !cap_q[i].dc_ok ||
            cap_q[i].nbits != 8 || cap_q[i].cs_low != 17 * (d + 1) ||
            cap_q[i].minh != d + 1 || cap_q[i].maxh != d + 1) begin
          errors++;
          $display("FAIL rnd_frame[%0d.%0d]: got dc%b 0x%02h bits%0d cs%0d half%0d..%0d want dc%b 0x%02h bits8 cs%0d half%0d",
                   r, i, cap_q[i].dc, cap_q[i].data, cap_q[i].nbits, cap_q[i].cs_low, cap_q[i].minh, cap_q[i].maxh,
                   burst[i][8], burst[i][7:0], 17 * (d + 1), d + 1);
        end
      end
      if (exp_ovf) ahb_write(4'h4, 32'h100);
    end
  endtask

  task automatic test_push_pop_same_cycle();
    logic [31:0] rd;
    logic [8:0]  extra;
    int c = 0;
    ahb_write(4'h8, 32'h0);
    for (int i = 0; i < 5; i++) burst[i] = 9'($urandom);
    extra = 9'($urandom);
    cap_q.delete();
    burst_write(5);
    while (OLED_CS_N !== 1'b1 && c < 100) begin @(negedge HCLK); c++; end
    vectors++; if (OLED_CS_N !== 1'b1) begin errors++; $display("FAIL pp_gap_wait: CS_N %b want 1", OLED_CS_N); end
    // Address phase in the gap puts the data phase on the idle pop cycle
    ahb_write(4'h0, {23'd0, extra});
    ahb_read(4'h4, rd);
    vectors++; if (rd !== 32'h23) begin errors++; $display("FAIL pp_status: got 0x%08h want 0x00000023", rd); end
    wait_frames(6, 300);
    wait_idle(50);
    vectors++; if (cap_q.size() != 6) begin errors++; $display("FAIL pp_count: got %0d want 6", cap_q.size()); end
    for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
      logic [8:0] want;
      want = (i < 5) ? burst[i] : extra;
      vectors++; if ({cap_q[i].dc, cap_q[i].data} !== want) begin
        errors++; $display("FAIL pp_order[%0d]: got 0x%03h want 0x%03h", i, {cap_q[i].dc, cap_q[i].data}, want);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    int c = 0;
    int rises0;
    ahb_write(4'h8, 32'h1);
    for (int i = 0; i < 3; i++) burst[i] = {1'b1, 8'($urandom)};
    cap_q.delete();
    burst_write(3);
    while (!(mon_in_frame && mon_bits >= 5) && c < 300) begin @(negedge HCLK); c++; end
    vectors++; if (!(mon_in_frame && mon_bits >= 5)) begin errors++; $display("FAIL abort_wait: bits %0d want 5", mon_bits); end
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    vectors++; if (OLED_SCLK !== 1'b1 || OLED_CS_N !== 1'b1 || OLED_SDIN !== 1'b1 || OLED_DC !== 1'b0) begin
      errors++; $display("FAIL abort_pins: sclk%b csn%b sdin%b dc%b want 1 1 1 0", OLED_SCLK, OLED_CS_N, OLED_SDIN, OLED_DC);
    end
    rises0 = sclk_rises;
    ahb_read(4'h4, rd);
    vectors++; if (rd !== 32'h4) begin errors++; $display("FAIL abort_status: got 0x%08h want 0x00000004", rd); end
    ahb_read(4'h8, rd);
    vectors++; if (rd !== 32'h3) begin errors++; $display("FAIL abort_clkdiv: got 0x%08h want 3", rd); end
    repeat (150) @(negedge HCLK);
    vectors++; if (sclk_rises != rises0) begin errors++; $display("FAIL abort_edges: got %0d rises want 0", sclk_rises - rises0); end
    vectors++; if (cap_q.size() != 0) begin errors++; $display("FAIL abort_frames: got %0d want 0", cap_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_clkdiv();
    test_overflow();
    test_random_bursts();
    test_push_pop_same_cycle();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
